// File: rtl/irq_vec_pkg.sv
// Shared types and constants for the mode-2 interrupt-acknowledge vector sequencer.
package irq_vec_pkg;

    localparam int unsigned VEC_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        WAIT_SLOT,
        DRIVE
    } state_e;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_UNRESOLVED = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT    = 2'b10;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ack_timeout_ctr.sv
// Cycle counter with synchronous clear and enable; tc flags that the next enabled edge
// is the LIMIT-th one since the last clear.
module ack_timeout_ctr #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tc = (cnt_q == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/irq_vector_sequencer.sv
// Mode-2 interrupt-acknowledge vector sequencer: stalls the CPU, waits for the owning slot's
// vector (or falls back to a per-channel default) and reports errors.
module irq_vector_sequencer
    import irq_vec_pkg::*;
#(
    parameter int unsigned NUM_IRQ_SLOTS  = 4,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ack_cycle,
    input  logic                             ack_chan,
    input  logic [2:0]                       ack_slot,
    input  logic                             ack_slot_valid,
    input  logic [NUM_IRQ_SLOTS-1:0]         slot_vec_rdy,
    input  logic [NUM_IRQ_SLOTS*VEC_W-1:0]   slot_vec_data,
    input  logic [VEC_W-1:0]                 dflt_vec0,
    input  logic [VEC_W-1:0]                 dflt_vec1,
    output logic                             cpu_wait_n,
    output logic [VEC_W-1:0]                 cpu_vec,
    output logic                             cpu_vec_oe,
    output logic                             ack_err,
    output logic [1:0]                       err_code,
    output logic [7:0]                       err_count
);

    state_e           state_q;
    logic             chan_q;
    logic [2:0]       slot_q;
    logic [3:0]       prev_q;

    logic [3:0]       sample;
    logic             match;
    logic             in_settle;
    logic             in_wait;
    logic             slot_ok;
    logic             settle_tc;
    logic             to_tc;
    logic             settle_done;
    logic             timeout;
    logic             fallback;
    logic [1:0]       fb_code;
    logic             sel_rdy;
    logic [VEC_W-1:0] sel_data;
    logic [VEC_W-1:0] dflt_vec;

    assign sample    = {ack_slot_valid, ack_slot};
    assign match     = (sample == prev_q);
    assign in_settle = (state_q == SETTLE);
    assign in_wait   = (state_q == WAIT_SLOT);
    // Out-of-range slot numbers have no vector source, so they count as unresolved.
    assign slot_ok   = ack_slot_valid && (32'(ack_slot) < NUM_IRQ_SLOTS);
    assign dflt_vec  = chan_q ? dflt_vec1 : dflt_vec0;

    // Resolver outputs are sampled every edge; SETTLE compares against the previous one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= sample;
        end
    end

    ack_timeout_ctr #(
        .LIMIT (SETTLE_CYCLES)
    ) u_settle_ctr (
        .clk  (clk),
        .rst  (rst),
        .load ((state_q == IDLE) || (in_settle && !match)),
        .en   (in_settle && match),
        .tc   (settle_tc)
    );

    ack_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (state_q == IDLE),
        .en   (in_settle || in_wait),
        .tc   (to_tc)
    );

    assign settle_done = in_settle && match && settle_tc;
    assign timeout     = (in_settle || in_wait) && to_tc;
    assign fallback    = timeout || (settle_done && !slot_ok);
    assign fb_code     = timeout ? ERR_TIMEOUT : ERR_UNRESOLVED;

    always_comb begin
        sel_rdy  = 1'b0;
        sel_data = '0;
        for (int s = 0; s < NUM_IRQ_SLOTS; s++) begin
            if (int'(slot_q) == s) begin
                sel_rdy  = slot_vec_rdy[s];
                sel_data = slot_vec_data[s*VEC_W +: VEC_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            chan_q     <= 1'b0;
            slot_q     <= '0;
            cpu_wait_n <= 1'b1;
            cpu_vec    <= '0;
            cpu_vec_oe <= 1'b0;
            ack_err    <= 1'b0;
            err_code   <= ERR_NONE;
            err_count  <= '0;
        end else begin
            ack_err <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ack_cycle) begin
                        state_q    <= SETTLE;
                        chan_q     <= ack_chan;
                        cpu_wait_n <= 1'b0;
                    end
                end
                SETTLE, WAIT_SLOT: begin
                    // Abort beats timeout, which beats any same-edge decision or rdy.
                    if (!ack_cycle) begin
                        state_q    <= IDLE;
                        cpu_wait_n <= 1'b1;
                        cpu_vec_oe <= 1'b0;
                    end else if (fallback) begin
                        state_q    <= DRIVE;
                        cpu_vec    <= dflt_vec;
                        cpu_vec_oe <= 1'b1;
                        cpu_wait_n <= 1'b1;
                        ack_err    <= 1'b1;
                        err_code   <= fb_code;
                        err_count  <= sat_inc(err_count);
                    end else if (settle_done) begin
                        state_q <= WAIT_SLOT;
                        slot_q  <= ack_slot;
                    end else if (in_wait && sel_rdy) begin
                        state_q    <= DRIVE;
                        cpu_vec    <= sel_data;
                        cpu_vec_oe <= 1'b1;
                        cpu_wait_n <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (!ack_cycle) begin
                        state_q    <= IDLE;
                        cpu_vec_oe <= 1'b0;
                        cpu_wait_n <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_vector_sequencer.sv
// Randomized bench for irq_vector_sequencer: each acknowledge is resolved by a
// transaction-level model over the per-edge stimulus it was given.
module tb_irq_vector_sequencer;

    localparam int unsigned NS = 4;
    localparam int unsigned SC = 2;
    localparam int unsigned TO = 16;
    localparam int          L  = TO + 1;

    logic          clk;
    logic          rst;
    logic          ack_cycle;
    logic          ack_chan;
    logic [2:0]    ack_slot;
    logic          ack_slot_valid;
    logic [NS-1:0] slot_vec_rdy;
    logic [NS*8-1:0] slot_vec_data;
    logic [7:0]    dflt_vec0;
    logic [7:0]    dflt_vec1;
    logic          cpu_wait_n;
    logic [7:0]    cpu_vec;
    logic          cpu_vec_oe;
    logic          ack_err;
    logic [1:0]    err_code;
    logic [7:0]    err_count;

    irq_vector_sequencer #(
        .NUM_IRQ_SLOTS  (NS),
        .SETTLE_CYCLES  (SC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ack_cycle      (ack_cycle),
        .ack_chan       (ack_chan),
        .ack_slot       (ack_slot),
        .ack_slot_valid (ack_slot_valid),
        .slot_vec_rdy   (slot_vec_rdy),
        .slot_vec_data  (slot_vec_data),
        .dflt_vec0      (dflt_vec0),
        .dflt_vec1      (dflt_vec1),
        .cpu_wait_n     (cpu_wait_n),
        .cpu_vec        (cpu_vec),
        .cpu_vec_oe     (cpu_vec_oe),
        .ack_err        (ack_err),
        .err_code       (err_code),
        .err_count      (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks;
    int         n_errors;
    logic [1:0] m_code;
    int         m_count;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_wait_n, input logic e_oe,
                              input logic e_err, input logic chk_vec, input logic [7:0] e_vec);
        check_val({tag, ".wait_n"}, 32'(cpu_wait_n), 32'(e_wait_n));
        check_val({tag, ".oe"}, 32'(cpu_vec_oe), 32'(e_oe));
        check_val({tag, ".ack_err"}, 32'(ack_err), 32'(e_err));
        check_val({tag, ".err_code"}, 32'(err_code), 32'(m_code));
        check_val({tag, ".err_count"}, 32'(err_count), 32'(m_count));
        if (chk_vec) check_val({tag, ".vec"}, 32'(cpu_vec), 32'(e_vec));
    endtask

    task automatic noise_inputs();
        ack_chan       = 1'($urandom);
        ack_slot       = 3'($urandom);
        ack_slot_valid = 1'($urandom);
        slot_vec_rdy   = 4'($urandom);
    endtask

    // kind: 0 clean, 1 invalid, 2 out-of-range slot, 3 toggle then settle, 4 rdy never,
    //       5 abort, 6 never settles, 7 rdy only at the timeout edge, 8 random glitches
    task automatic run_txn(input int kind, input bit rst_in_drive);
        logic       chan;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [31:0] data;
        logic [3:0] smp [L];
        logic [3:0] rdy_a [L];
        bit         cyc_a [L];
        logic [3:0] good_s;
        logic [3:0] other_s;
        int slot, rdy_from, ttog, abort_at, es, done_k, abort_k, limit, end_k, sl, h, g;
        bit resolved, is_abort, is_err;
        logic [1:0] e_code;
        logic [7:0] e_vec;

        chan     = 1'($urandom);
        d0       = 8'($urandom);
        d1       = 8'($urandom);
        data     = $urandom;
        slot     = $urandom_range(0, NS - 1);
        good_s   = {1'b1, 3'(slot)};
        other_s  = {1'b1, 3'((slot + 1 + $urandom_range(0, 2)) % NS)};
        rdy_from = $urandom_range(1, 6);
        ttog     = $urandom_range(1, 8);
        abort_at = $urandom_range(1, 6);
        for (int k = 0; k < L; k++) begin
            cyc_a[k] = 1'b1;
            smp[k]   = good_s;
        end
        case (kind)
            1: begin
                other_s = {1'b0, 3'($urandom)};
                for (int k = 0; k < L; k++) smp[k] = other_s;
            end
            2: begin
                other_s = {1'b1, 3'($urandom_range(4, 7))};
                for (int k = 0; k < L; k++) smp[k] = other_s;
            end
            3: for (int k = 0; k < ttog; k++) smp[k] = (k % 2 == 0) ? other_s : good_s;
            4: rdy_from = L;
            5: for (int k = abort_at; k < L; k++) cyc_a[k] = 1'b0;
            6: for (int k = 0; k < L; k++) smp[k] = (k % 2 == 0) ? other_s : good_s;
            7: rdy_from = TO;
            8: for (int k = 0; k < L; k++) begin
                if ($urandom_range(0, 3) == 0) smp[k] = {1'($urandom), 3'($urandom_range(0, 4))};
            end
            default: ;
        endcase
        for (int k = 0; k < L; k++) begin
            rdy_a[k] = 4'($urandom);
            rdy_a[k][slot] = (k >= rdy_from);
        end

        // Model: decision at the first edge closing SC+1 equal samples; drive on the first
        // rdy after it; timeout at edge TO wins ties; an abort at or before that wins all.
        es = -1;
        for (int k = SC; k < L && es < 0; k++) begin
            bit st = 1'b1;
            for (int j = 1; j <= SC; j++) if (smp[k - j] != smp[k]) st = 1'b0;
            if (st) es = k;
        end
        resolved = (es >= 0) && smp[es][3] && (int'(smp[es][2:0]) < NS);
        sl       = resolved ? int'(smp[es][2:0]) : 0;
        done_k   = -1;
        if (es >= 0) begin
            if (!resolved) done_k = es;
            else for (int k = es + 1; k < L; k++) if (done_k < 0 && rdy_a[k][sl]) done_k = k;
        end
        abort_k = -1;
        for (int k = 1; k < L; k++) if (abort_k < 0 && !cyc_a[k]) abort_k = k;
        limit    = (done_k >= 0 && done_k < TO) ? done_k : TO;
        is_abort = (abort_k >= 0) && (abort_k <= limit);
        is_err   = 1'b0;
        e_code   = 2'b00;
        e_vec    = 8'h00;
        if (is_abort) begin
            end_k = abort_k;
        end else if (limit == TO) begin
            end_k = TO; is_err = 1'b1; e_code = 2'b10; e_vec = chan ? d1 : d0;
        end else if (!resolved) begin
            end_k = done_k; is_err = 1'b1; e_code = 2'b01; e_vec = chan ? d1 : d0;
        end else begin
            end_k = done_k; e_vec = data[8*sl +: 8];
        end

        dflt_vec0     = d0;
        dflt_vec1     = d1;
        slot_vec_data = data;
        for (int k = 0; k <= end_k; k++) begin
            ack_cycle      = cyc_a[k];
            ack_chan       = (k == 0) ? chan : 1'($urandom);
            ack_slot_valid = smp[k][3];
            ack_slot       = smp[k][2:0];
            slot_vec_rdy   = rdy_a[k];
            @(posedge clk);
            #1;
            if (k < end_k) begin
                check_outs("busy", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            end else if (is_abort) begin
                check_outs("abort", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            end else begin
                if (is_err) begin
                    m_code  = e_code;
                    m_count = (m_count < 255) ? m_count + 1 : 255;
                end
                check_outs("drive", 1'b1, 1'b1, is_err, 1'b1, e_vec);
            end
        end

        if (!is_abort && rst_in_drive) begin
            #3;
            rst = 1'b1;
            m_code  = 2'b00;
            m_count = 0;
            #1;
            check_outs("async_rst", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
            ack_cycle = 1'b0;
            #2;
            rst = 1'b0;
            return;
        end

        if (!is_abort) begin
            h = $urandom_range(0, 2);
            for (int i = 0; i < h; i++) begin
                noise_inputs();
                ack_cycle = 1'b1;
                @(posedge clk);
                #1;
                check_outs("hold", 1'b1, 1'b1, 1'b0, 1'b1, e_vec);
            end
            noise_inputs();
            ack_cycle = 1'b0;
            @(posedge clk);
            #1;
            check_outs("release", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        end

        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin
            noise_inputs();
            ack_cycle = 1'b0;
            @(posedge clk);
            #1;
            check_outs("idle", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        m_code         = 2'b00;
        m_count        = 0;
        rst            = 1'b1;
        ack_cycle      = 1'b0;
        ack_chan       = 1'b0;
        ack_slot       = 3'd0;
        ack_slot_valid = 1'b0;
        slot_vec_rdy   = '0;
        slot_vec_data  = '0;
        dflt_vec0      = 8'h00;
        dflt_vec1      = 8'h00;
        #22;
        check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outs("post_reset_idle", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        for (int kind = 0; kind <= 8; kind++) run_txn(kind, 1'b0);
        for (int i = 0; i < 300; i++) run_txn($urandom_range(0, 8), 1'b0);
        for (int i = 0; i < 260; i++) run_txn(4, 1'b0);
        check_val("err_count_saturated", 32'(err_count), 32'd255);
        run_txn(0, 1'b1);
        for (int i = 0; i < 20; i++) run_txn($urandom_range(0, 8), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
